// File: rtl/max_stream_ctrl_pkg.sv
// max_stream_ctrl_pkg: shared state type, default sizes and max-select helper
package max_stream_ctrl_pkg;

    localparam int W_DEF = 8;
    localparam int N_MAX_DEF = 16;

    typedef enum logic [1:0] {IDLE, COLLECT, DONE} state_t;

    function automatic logic [W_DEF-1:0] max2(input logic [W_DEF-1:0] a, input logic [W_DEF-1:0] b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/max_stream_ctrl_max2_cmp.sv
// max2_cmp: unsigned strict greater-than compare of a candidate against the current max
module max2_cmp #(
    parameter int W = 8
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic         gt,
    output logic [W-1:0] y
);

    // Ties report gt=0 so the earlier value (and its index) is kept.
    always_comb begin
        gt = a > b;
        y = gt ? a : b;
    end

endmodule

// File: rtl/max_stream_ctrl.sv
// max_stream_ctrl: collects a burst of samples and reports the peak and its first index
module max_stream_ctrl
    import max_stream_ctrl_pkg::*;
#(
    parameter int W = W_DEF,
    parameter int N_MAX = N_MAX_DEF,
    localparam int LEN_W = $clog2(N_MAX + 1),
    localparam int IDX_W = (N_MAX > 1) ? $clog2(N_MAX) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [LEN_W-1:0] len,
    input  logic             in_valid,
    input  logic [W-1:0]     in_data,
    output logic             in_ready,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [W-1:0]     out_max,
    output logic [IDX_W-1:0] out_idx,
    output logic             out_empty,
    output logic             busy
);

    state_t state;
    logic [LEN_W-1:0] cnt;
    logic [LEN_W-1:0] len_eff;
    logic gt;
    logic [W-1:0] sel;
    logic accept;

    max2_cmp #(.W(W)) u_cmp (
        .a  (in_data),
        .b  (out_max),
        .gt (gt),
        .y  (sel)
    );

    // Handshake and status flags decode directly from the state register.
    always_comb begin
        in_ready = state == COLLECT;
        out_valid = state == DONE;
        busy = state != IDLE;
        accept = in_valid && in_ready;
    end

    // Burst FSM: running max lives in out_max so the result needs no extra copy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt <= '0;
            len_eff <= '0;
            out_max <= '0;
            out_idx <= '0;
            out_empty <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        cnt <= '0;
                        len_eff <= (len > LEN_W'(N_MAX)) ? LEN_W'(N_MAX) : len;
                        if (len == '0) begin
                            state <= DONE;
                            out_max <= '0;
                            out_idx <= '0;
                            out_empty <= 1'b1;
                        end else begin
                            state <= COLLECT;
                        end
                    end
                end
                COLLECT: begin
                    if (accept) begin
                        if (cnt == '0 || gt) begin
                            out_max <= (cnt == '0) ? in_data : sel;
                            out_idx <= IDX_W'(cnt);
                        end
                        if (cnt == len_eff - LEN_W'(1)) begin
                            state <= DONE;
                            cnt <= '0;
                        end else begin
                            cnt <= cnt + LEN_W'(1);
                        end
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state <= IDLE;
                        out_empty <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_max_stream_ctrl.sv
// tb_max_stream_ctrl: directed-vector bench for max_stream_ctrl
module tb_max_stream_ctrl;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start = 1'b0;
    logic [4:0] len = '0;
    logic in_valid = 1'b0;
    logic [7:0] in_data = '0;
    logic in_ready;
    logic out_valid;
    logic out_ready = 1'b1;
    logic [7:0] out_max;
    logic [3:0] out_idx;
    logic out_empty;
    logic busy;

    int tests = 0;
    int fails = 0;
    logic [7:0] q[$];

    max_stream_ctrl dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .len       (len),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_max   (out_max),
        .out_idx   (out_idx),
        .out_empty (out_empty),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_in_ready"}, in_ready, 0);
        check({tag, "_out_valid"}, out_valid, 0);
        check({tag, "_out_empty"}, out_empty, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_out_max"}, out_max, 0);
        check({tag, "_out_idx"}, out_idx, 0);
    endtask

    task automatic check_res(input string tag, input logic [7:0] m, input logic [3:0] i, input logic e);
        check({tag, "_valid"}, out_valid, 1);
        check({tag, "_max"}, out_max, m);
        check({tag, "_idx"}, out_idx, i);
        check({tag, "_empty"}, out_empty, e);
        check({tag, "_in_ready"}, in_ready, 0);
    endtask

    task automatic do_start(input logic [4:0] l);
        start = 1'b1;
        len = l;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic send_q(input int gap);
        foreach (q[k]) begin
            repeat (gap) begin
                in_valid = 1'b0;
                check("gap_ready", in_ready, 1);
                @(negedge clk);
            end
            in_valid = 1'b1;
            in_data = q[k];
            check("in_ready", in_ready, 1);
            @(negedge clk);
        end
        in_valid = 1'b0;
    endtask

    initial begin
        repeat (2) @(negedge clk);
        check_zero("reset");
        rst_n = 1'b1;
        @(negedge clk);

        do_start(5'd4);
        q = '{8'd3, 8'd9, 8'd9, 8'd2};
        send_q(0);
        check_res("basic", 8'd9, 4'd1, 1'b0);
        @(negedge clk);
        check("basic_idle_valid", out_valid, 0);
        check("basic_idle_busy", busy, 0);

        do_start(5'd1);
        q = '{8'hFF};
        send_q(0);
        check_res("one", 8'hFF, 4'd0, 1'b0);
        @(negedge clk);

        do_start(5'd0);
        check_res("empty", 8'd0, 4'd0, 1'b1);
        @(negedge clk);
        check("empty_clr_valid", out_valid, 0);
        check("empty_clr_flag", out_empty, 0);
        check("empty_clr_ready", in_ready, 0);

        do_start(5'd3);
        q = '{8'd5, 8'd7, 8'd200};
        send_q(2);
        check_res("gaps", 8'd200, 4'd2, 1'b0);
        @(negedge clk);

        out_ready = 1'b0;
        do_start(5'd4);
        q = '{8'd3, 8'd9, 8'd9, 8'd2};
        send_q(0);
        for (int c = 0; c < 5; c++) begin
            start = 1'b1;
            len = 5'd1;
            check_res("hold", 8'd9, 4'd1, 1'b0);
            @(negedge clk);
        end
        start = 1'b0;
        out_ready = 1'b1;
        check_res("hold_last", 8'd9, 4'd1, 1'b0);
        @(negedge clk);
        check("hold_clr_valid", out_valid, 0);
        @(negedge clk);
        check("hold_no_queue", busy, 0);

        do_start(5'd20);
        q.delete();
        for (int v = 0; v < 15; v++) q.push_back(8'(v));
        send_q(0);
        check("sat_pre_valid", out_valid, 0);
        q = '{8'd15};
        send_q(0);
        check_res("sat", 8'd15, 4'd15, 1'b0);
        @(negedge clk);

        do_start(5'd4);
        q = '{8'd3, 8'd9};
        send_q(0);
        check("mid_busy", busy, 1);
        rst_n = 1'b0;
        #1;
        check_zero("midrst");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        do_start(5'd2);
        q = '{8'd1, 8'd4};
        send_q(0);
        check_res("after_rst", 8'd4, 4'd1, 1'b0);
        @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
